// File: rtl/tetris_input_pkg.sv
// Shared types and scancode constants for the PS/2 key event controller.
// Holds the action enum, decode FSM states and the scancode-to-action lookup.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    ACT_LEFT   = 3'd0,
    ACT_RIGHT  = 3'd1,
    ACT_DOWN   = 3'd2,
    ACT_ROTATE = 3'd3,
    ACT_DROP   = 3'd4,
    ACT_HOLD   = 3'd5,
    ACT_PAUSE  = 3'd6
  } action_e;

  localparam int N_ACTIONS = 7;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  localparam logic [7:0] SC_LEFT_EXT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT_EXT  = 8'h74;
  localparam logic [7:0] SC_DOWN_EXT   = 8'h72;
  localparam logic [7:0] SC_ROTATE_EXT = 8'h75;
  localparam logic [7:0] SC_LEFT       = 8'h1C;
  localparam logic [7:0] SC_RIGHT      = 8'h23;
  localparam logic [7:0] SC_DOWN       = 8'h1B;
  localparam logic [7:0] SC_ROTATE     = 8'h1D;
  localparam logic [7:0] SC_DROP       = 8'h29;
  localparam logic [7:0] SC_HOLD       = 8'h21;
  localparam logic [7:0] SC_PAUSE      = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic    hit;
    action_e act;
  } key_lookup_t;

  // Extended and normal code spaces are distinct: 6B alone is not LEFT.
  function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.act = ACT_LEFT;
    if (ext) begin
      case (code)
        SC_LEFT_EXT:   r.act = ACT_LEFT;
        SC_RIGHT_EXT:  r.act = ACT_RIGHT;
        SC_DOWN_EXT:   r.act = ACT_DOWN;
        SC_ROTATE_EXT: r.act = ACT_ROTATE;
        default:       r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_LEFT:   r.act = ACT_LEFT;
        SC_RIGHT:  r.act = ACT_RIGHT;
        SC_DOWN:   r.act = ACT_DOWN;
        SC_ROTATE: r.act = ACT_ROTATE;
        SC_DROP:   r.act = ACT_DROP;
        SC_HOLD:   r.act = ACT_HOLD;
        SC_PAUSE:  r.act = ACT_PAUSE;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small registered FIFO for game-action events.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign wr_d   = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d   = pop_ok  ? rd_q + 1'b1 : rd_q;
  assign data_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scancode sequencer producing Tetris action events through a small FIFO.
// Define AUTOREPEAT_EN to compile in DAS/ARR auto-repeat for LEFT, RIGHT and DOWN.
module ps2_key_event_ctrl
  import tetris_input_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int DAS_CYC     = 16_000_000,
  parameter int ARR_CYC     = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           scan_byte,
  input  logic                 scan_valid,
  output action_e              evt_action,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [N_ACTIONS-1:0] key_held,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  scan_state_e          state_q, state_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 tmo_hit;
  logic                 is_make, is_brk, is_ext;
  key_lookup_t          lk;
  logic                 evt_make_q, evt_brk_q;
  action_e              evt_act_q;
  logic [N_ACTIONS-1:0] held_q, held_d;
  logic                 ovf_q, ovf_d;
  logic                 dec_push;
  logic                 push_valid;
  action_e              push_act;
  logic [2:0]           fifo_head;
  logic                 fifo_empty, fifo_full;
  logic                 drop;

  assign tmo_hit = (state_q != ST_IDLE) && !scan_valid &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_byte == SC_E0)      state_d = ST_EXT;
          else if (scan_byte == SC_F0) state_d = ST_BRK;
        end
        ST_EXT: begin
          if (scan_byte == SC_F0)      state_d = ST_EXT_BRK;
          else if (scan_byte != SC_E0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: is_make = (scan_byte != SC_E0) && (scan_byte != SC_F0);
        ST_EXT: begin
          is_make = (scan_byte != SC_E0) && (scan_byte != SC_F0);
          is_ext  = 1'b1;
        end
        ST_BRK:  is_brk = 1'b1;
        default: begin
          is_brk = 1'b1;
          is_ext = 1'b1;
        end
      endcase
    end
  end

  // Counter only advances while a prefix is waiting for its completing byte.
  always_comb begin
    tmo_d = tmo_q + TMO_W'(1);
    if (scan_valid || (state_q == ST_IDLE) || tmo_hit) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign lk = lookup_key(is_ext, scan_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_make_q <= 1'b0;
      evt_brk_q  <= 1'b0;
      evt_act_q  <= ACT_LEFT;
    end else begin
      evt_make_q <= is_make && lk.hit;
      evt_brk_q  <= is_brk && lk.hit;
      evt_act_q  <= lk.act;
    end
  end

  // Only the first make of a held key is an event; typematic repeats are absorbed.
  assign dec_push = evt_make_q && !held_q[evt_act_q];

  always_comb begin
    held_d = held_q;
    if (evt_make_q) held_d[evt_act_q] = 1'b1;
    if (evt_brk_q)  held_d[evt_act_q] = 1'b0;
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic             rpt_active_q, rpt_active_d;
  logic             rpt_arr_q, rpt_arr_d;
  logic             rpt_pend_q, rpt_pend_d;
  action_e          rpt_key_q, rpt_key_d;
  action_e          rpt_pend_act_q, rpt_pend_act_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire;
  logic             rpt_req;
  action_e          rpt_req_act;
  logic             new_rpt_key;

  assign new_rpt_key = dec_push && (evt_act_q inside {ACT_LEFT, ACT_RIGHT, ACT_DOWN});

  always_comb begin
    rpt_active_d = rpt_active_q;
    rpt_arr_d    = rpt_arr_q;
    rpt_key_d    = rpt_key_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_fire     = 1'b0;
    if (new_rpt_key) begin
      rpt_key_d    = evt_act_q;
      rpt_active_d = 1'b1;
      rpt_arr_d    = 1'b0;
      rpt_cnt_d    = '0;
    end else if (evt_brk_q && rpt_active_q && (evt_act_q == rpt_key_q)) begin
      rpt_active_d = 1'b0;
      rpt_arr_d    = 1'b0;
      rpt_cnt_d    = '0;
    end else if (rpt_active_q) begin
      if (rpt_cnt_q == (rpt_arr_q ? RPT_W'(ARR_CYC - 1) : RPT_W'(DAS_CYC - 1))) begin
        rpt_fire  = 1'b1;
        rpt_arr_d = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  // A repeat colliding with a decode push waits exactly one cycle.
  assign rpt_req     = rpt_fire || rpt_pend_q;
  assign rpt_req_act = rpt_pend_q ? rpt_pend_act_q : rpt_key_q;

  always_comb begin
    rpt_pend_d     = 1'b0;
    rpt_pend_act_d = rpt_key_q;
    if (dec_push) begin
      rpt_pend_d     = rpt_req;
      rpt_pend_act_d = rpt_req_act;
    end else if (rpt_pend_q && rpt_fire) begin
      rpt_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active_q   <= 1'b0;
      rpt_arr_q      <= 1'b0;
      rpt_pend_q     <= 1'b0;
      rpt_key_q      <= ACT_LEFT;
      rpt_pend_act_q <= ACT_LEFT;
      rpt_cnt_q      <= '0;
    end else begin
      rpt_active_q   <= rpt_active_d;
      rpt_arr_q      <= rpt_arr_d;
      rpt_pend_q     <= rpt_pend_d;
      rpt_key_q      <= rpt_key_d;
      rpt_pend_act_q <= rpt_pend_act_d;
      rpt_cnt_q      <= rpt_cnt_d;
    end
  end

  assign push_valid = dec_push || rpt_req;
  assign push_act   = dec_push ? evt_act_q : rpt_req_act;
`else
  // Repeat timing parameters are accepted but have no effect in this build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{DAS_CYC, ARR_CYC};

  assign push_valid = dec_push;
  assign push_act   = evt_act_q;
`endif

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_valid),
    .data_i  (push_act),
    .pop_i   (evt_ready),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign drop = push_valid && fifo_full && !evt_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      ovf_q  <= ovf_d;
    end
  end

  assign evt_action = action_e'(fifo_head);
  assign evt_valid  = !fifo_empty;
  assign key_held   = held_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: directed scenarios plus a random key phase.
// Expected events come from a key-level model (held set + expected event queue).
module tb_ps2_key_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] scan_byte = 8'h00;
  logic       scan_valid = 1'b0;
  logic [2:0] evt_action;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [6:0] key_held;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;

  logic [2:0] gotAct[$];
  int         gotCyc[$];
  logic [2:0] expAct[$];
  logic [6:0] modelHeld = '0;

  logic [7:0] codeNorm [7] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h21, 8'h76};
  logic [7:0] codeExt  [4] = '{8'h6B, 8'h74, 8'h72, 8'h75};

  ps2_key_event_ctrl #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (50),
    .DAS_CYC     (20),
    .ARR_CYC     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_byte  (scan_byte),
    .scan_valid (scan_valid),
    .evt_action (evt_action),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .key_held   (key_held),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Every accepted pop is logged with the cycle it happened in.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      gotAct.push_back(evt_action);
      gotCyc.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    scan_byte  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key-level model: a new press of an unheld key yields one event.
  task automatic pressKey(input int act, input bit ext);
    if (ext) applyStimulus(8'hE0);
    applyStimulus(ext ? codeExt[act] : codeNorm[act]);
    if (!modelHeld[act]) begin
      expAct.push_back(3'(act));
      modelHeld[act] = 1'b1;
    end
  endtask

  task automatic releaseKey(input int act, input bit ext);
    if (ext) applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(ext ? codeExt[act] : codeNorm[act]);
    modelHeld[act] = 1'b0;
  endtask

  task automatic checkEvents(input string tag);
    checkOutput({tag, "_count"}, gotAct.size(), expAct.size());
    for (int i = 0; i < expAct.size(); i++)
      checkOutput($sformatf("%s_evt%0d", tag, i),
                  (gotAct.size() > i) ? 32'(gotAct[i]) : 32'hFFFF_FFFF, 32'(expAct[i]));
    gotAct.delete();
    gotCyc.delete();
    expAct.delete();
  endtask

  initial begin
    int maxAct;
    #2 rst_n = 1'b0;
    waitCycles(3);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_action", evt_action, 0);
    checkOutput("rst_held", key_held, 0);
    checkOutput("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    waitCycles(2);

    // Plain make then break of LEFT.
    pressKey(0, 1'b0);
    checkOutput("t1_held_make", key_held, modelHeld);
    releaseKey(0, 1'b0);
    checkOutput("t1_held_brk", key_held, modelHeld);
    waitCycles(4);
    checkEvents("t1");

    // Extended ROTATE.
    pressKey(3, 1'b1);
    checkOutput("t2_held_make", key_held, modelHeld);
    releaseKey(3, 1'b1);
    checkOutput("t2_held_brk", key_held, modelHeld);
    waitCycles(4);
    checkEvents("t2");

    // Typematic repeats of DROP collapse into one event.
    pressKey(4, 1'b0);
    pressKey(4, 1'b0);
    pressKey(4, 1'b0);
    releaseKey(4, 1'b0);
    waitCycles(4);
    checkEvents("t3");

    // Overflow with the consumer stalled.
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) continue;
      pressKey(k, 1'b0);
      releaseKey(k, 1'b0);
    end
    expAct.delete();
    expAct.push_back(3'd0);
    expAct.push_back(3'd1);
    expAct.push_back(3'd2);
    expAct.push_back(3'd4);
    checkOutput("t4_ovf_set", overflow, 1);
    checkOutput("t4_valid", evt_valid, 1);
    checkOutput("t4_head_stable", evt_action, 0);
    checkOutput("t4_held", key_held, modelHeld);
    ovf_clr = 1'b1;
    waitCycles(1);
    ovf_clr = 1'b0;
    waitCycles(1);
    checkOutput("t4_ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    waitCycles(8);
    checkEvents("t4");
    checkOutput("t4_empty", evt_valid, 0);

    // Dangling E0 times out, so 74 is an unmapped normal make.
    applyStimulus(8'hE0);
    waitCycles(60);
    applyStimulus(8'h74);
    waitCycles(4);
    checkOutput("t5_held", key_held, 0);
    checkEvents("t5");

    // RIGHT held long enough for DAS plus one ARR step.
    pressKey(1, 1'b0);
    waitCycles(22);
    releaseKey(1, 1'b0);
    waitCycles(50);
`ifdef AUTOREPEAT_EN
    expAct.push_back(3'd1);
    expAct.push_back(3'd1);
    checkOutput("t6_das", (gotCyc.size() > 1) ? 32'(gotCyc[1] - gotCyc[0]) : 32'hFFFF_FFFF, 20);
    checkOutput("t6_arr", (gotCyc.size() > 2) ? 32'(gotCyc[2] - gotCyc[0]) : 32'hFFFF_FFFF, 28);
`endif
    checkOutput("t6_held", key_held, modelHeld);
    checkEvents("t6");

    // Reset in the middle of E0 F0.
    pressKey(4, 1'b0);
    waitCycles(4);
    checkEvents("t7_pre");
    checkOutput("t7_held_pre", key_held, modelHeld);
    applyStimulus(8'hE0);
    scan_byte  = 8'hF0;
    scan_valid = 1'b1;
    waitCycles(1);
    scan_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    modelHeld = '0;
    checkOutput("t7_rst_held", key_held, 0);
    checkOutput("t7_rst_valid", evt_valid, 0);
    checkOutput("t7_rst_action", evt_action, 0);
    checkOutput("t7_rst_ovf", overflow, 0);
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(8'h6B);
    waitCycles(4);
    checkOutput("t7_held_post", key_held, 0);
    checkEvents("t7");

    // Random key activity against the key-level model.
`ifdef AUTOREPEAT_EN
    maxAct = 3;
`else
    maxAct = 0;
`endif
    for (int it = 0; it < 40; it++) begin
      int act;
      int roll;
      bit ext;
      act  = $urandom_range(6, maxAct);
      ext  = (act < 4) ? 1'($urandom_range(1, 0)) : 1'b0;
      roll = $urandom_range(9, 0);
      if (roll < 5)      pressKey(act, ext);
      else if (roll < 9) releaseKey(act, ext);
      else               applyStimulus(8'h15);
      waitCycles($urandom_range(3, 0));
      checkOutput($sformatf("rnd_held%0d", it), key_held, modelHeld);
    end
    waitCycles(6);
    checkEvents("rnd");
    checkOutput("rnd_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
